// File: rtl/sw_sb_ctrl.sv
// Bus responder for the 16 board switches: synchronise, debounce (when SW_DEBOUNCE_EN is defined),
// record per-bit change flags and raise a level interrupt request cleared by the interrupt return.
module sw_sb_ctrl #(
  parameter int DEBOUNCE_CYCLES = 100_000
) (
  input  logic        clk_i,
  input  logic        rst,
  input  logic        req_i,
  input  logic        write_enable_i,
  input  logic [31:0] addr_i,
  input  logic [31:0] write_data_i,
  output logic [31:0] read_data_o,
  input  logic [15:0] sw_i,
  output logic        interrupt_request_o,
  input  logic        interrupt_return_i
);

  localparam logic [31:0] ADDR_VALUE  = 32'h0000_0000;
  localparam logic [31:0] ADDR_CHANGE = 32'h0000_0004;
  localparam logic [31:0] ADDR_IRQ_EN = 32'h0000_0008;
  localparam logic [31:0] ADDR_RESET  = 32'h0000_0024;

  logic [15:0] sw_meta;
  logic [15:0] sw_sync;
  logic [15:0] sw_stable;
  logic [15:0] sw_stable_next;
  logic [15:0] chg_flags;
  logic [15:0] chg_set;
  logic [15:0] chg_clr;
  logic [15:0] chg_next;
  logic        irq_en;
  logic        irq_en_next;
  logic        irq_pending;
  logic        irq_pending_next;
  logic        wr;
  logic        rd;
  logic        soft_rst;
  logic [31:0] rd_mux;

  assign wr       = req_i & write_enable_i;
  assign rd       = req_i & ~write_enable_i;
  assign soft_rst = rst | (wr && addr_i == ADDR_RESET && write_data_i == 32'd1);

`ifdef SW_DEBOUNCE_EN
  localparam int              CW      = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0]   CNT_MAX = CW'(DEBOUNCE_CYCLES - 1);

  logic [15:0]   candidate;
  logic [CW-1:0] counter;

  // Any difference anywhere in the vector restarts the quiet window for all bits.
  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      candidate <= '0;
      counter   <= '0;
    end else if (sw_sync != candidate) begin
      candidate <= sw_sync;
      counter   <= '0;
    end else if (counter != CNT_MAX) begin
      counter <= counter + 1'b1;
    end
  end

  assign sw_stable_next = (counter == CNT_MAX) ? candidate : sw_stable;
`else
  logic unused_cfg;
  assign unused_cfg     = (DEBOUNCE_CYCLES > 1);
  assign sw_stable_next = sw_sync;
`endif

  // NOTE: every variable gets a default at the top of always_comb so no path infers a latch.
  always_comb begin
    chg_set = sw_stable_next ^ sw_stable;
    chg_clr = '0;
    if (wr && addr_i == ADDR_CHANGE && write_data_i <= 32'h0000_FFFF)
      chg_clr = write_data_i[15:0];
    // OR-ing the set term last makes a same-cycle change win over the W1C.
    chg_next = (chg_flags & ~chg_clr) | chg_set;

    irq_en_next = irq_en;
    if (wr && addr_i == ADDR_IRQ_EN && write_data_i < 32'd2)
      irq_en_next = write_data_i[0];

    irq_pending_next = irq_en_next &
                       ((irq_pending & ~interrupt_return_i) | (irq_en & |(chg_set & ~chg_flags)));

    case (addr_i)
      ADDR_VALUE:  rd_mux = {16'b0, sw_stable};
      ADDR_CHANGE: rd_mux = {16'b0, chg_flags};
      ADDR_IRQ_EN: rd_mux = {31'b0, irq_en};
      default:     rd_mux = '0;
    endcase
  end

  // NOTE: state flops use <= so each one samples the pre-edge value of the others.
  always_ff @(posedge clk_i) begin
    if (soft_rst) begin
      sw_meta     <= '0;
      sw_sync     <= '0;
      sw_stable   <= '0;
      chg_flags   <= '0;
      irq_en      <= 1'b0;
      irq_pending <= 1'b0;
      read_data_o <= '0;
    end else begin
      sw_meta     <= sw_i;
      sw_sync     <= sw_meta;
      sw_stable   <= sw_stable_next;
      chg_flags   <= chg_next;
      irq_en      <= irq_en_next;
      irq_pending <= irq_pending_next;
      if (rd)
        read_data_o <= rd_mux;
    end
  end

  assign interrupt_request_o = irq_pending;

endmodule

// File: tb/tb_sw_sb_ctrl.sv
// Self-checking bench for sw_sb_ctrl: reads go through a scoreboard queue, IRQ levels are checked directly.
module tb_sw_sb_ctrl;

`ifdef SW_DEBOUNCE_EN
  localparam int LAT = 7;
`else
  localparam int LAT = 3;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        req_i;
  logic        write_enable_i;
  logic [31:0] addr_i;
  logic [31:0] write_data_i;
  logic [31:0] read_data_o;
  logic [15:0] sw_i;
  logic        interrupt_request_o;
  logic        interrupt_return_i;

  int errors = 0;
  int checks = 0;

  logic [31:0] exp_q[$];
  string       name_q[$];
  logic        rd_issued = 1'b0;

  always #5 clk = ~clk;

  sw_sb_ctrl #(.DEBOUNCE_CYCLES(4)) dut (
    .clk_i              (clk),
    .rst                (rst),
    .req_i              (req_i),
    .write_enable_i     (write_enable_i),
    .addr_i             (addr_i),
    .write_data_i       (write_data_i),
    .read_data_o        (read_data_o),
    .sw_i               (sw_i),
    .interrupt_request_o(interrupt_request_o),
    .interrupt_return_i (interrupt_return_i)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: a read captured on a rising edge is compared on the following falling edge.
  always @(posedge clk) rd_issued <= req_i & ~write_enable_i & ~rst;

  always @(negedge clk) begin
    if (rd_issued) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_read: got %h with no expectation queued", read_data_o);
      end else begin
        check(name_q.pop_front(), read_data_o, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    req_i = 1'b1; write_enable_i = 1'b1; addr_i = a; write_data_i = d;
    tick();
    req_i = 1'b0; write_enable_i = 1'b0;
  endtask

  task automatic bus_read(input string name, input logic [31:0] a, input logic [31:0] e);
    req_i = 1'b1; write_enable_i = 1'b0; addr_i = a;
    exp_q.push_back(e);
    name_q.push_back(name);
    tick();
    req_i = 1'b0;
  endtask

  // Bit0 toggles every 2 cycles for 20 cycles, then holds 1 from cycle 20.
  function automatic logic [15:0] toggle_drv(input int k);
    if (k < 0)   return 16'h0080;
    if (k >= 20) return 16'h0081;
    return (((k / 2) % 2) == 0) ? 16'h0081 : 16'h0080;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] e;
    rst = 1'b1; req_i = 1'b0; write_enable_i = 1'b0; addr_i = '0; write_data_i = '0;
    sw_i = 16'hFFFF; interrupt_return_i = 1'b0;

    // 1: reset state, then switches settle to all ones
    idle(2);
    rst = 1'b0;
    check("reset_read_data", read_data_o, 32'h0);
    check("reset_irq", 32'(interrupt_request_o), 32'h0);
    idle(LAT + 3);
    bus_read("value_ffff", 32'h00, 32'h0000_FFFF);
    bus_read("change_ffff", 32'h04, 32'h0000_FFFF);
    check("irq_disabled", 32'(interrupt_request_o), 32'h0);

    // 2: interrupt on a change, return, W1C
    sw_i = 16'h0000;
    idle(LAT + 3);
    bus_write(32'h04, 32'h0000_FFFF);
    bus_read("change_cleared", 32'h04, 32'h0);
    bus_write(32'h08, 32'h1);
    sw_i = 16'h0081;
    idle(LAT - 1);
    check("irq_before_update", 32'(interrupt_request_o), 32'h0);
    tick();
    check("irq_on_update", 32'(interrupt_request_o), 32'h1);
    bus_read("value_0081", 32'h00, 32'h0000_0081);
    interrupt_return_i = 1'b1;
    tick();
    interrupt_return_i = 1'b0;
    check("irq_after_return", 32'(interrupt_request_o), 32'h0);
    bus_read("change_0081", 32'h04, 32'h0000_0081);
    bus_write(32'h04, 32'h1);
    bus_read("change_w1c", 32'h04, 32'h0000_0080);
    check("irq_after_w1c", 32'(interrupt_request_o), 32'h0);

    // bit0 falls with IRQ enabled; clearing IRQ_EN drops the request next cycle
    sw_i = 16'h0080;
    idle(LAT + 2);
    check("irq_bit0_fall", 32'(interrupt_request_o), 32'h1);
    bus_write(32'h08, 32'h0);
    check("irq_en_clear", 32'(interrupt_request_o), 32'h0);

    // 3: bouncing bit0, VALUE read every cycle
    for (int k = 0; k <= 31; k++) begin
      sw_i = toggle_drv(k);
`ifdef SW_DEBOUNCE_EN
      e = (k <= 26) ? 32'h0000_0080 : 32'h0000_0081;
`else
      e = {16'b0, toggle_drv(k - 3)};
`endif
      bus_read("bounce_value", 32'h00, e);
    end

    // 4: bus corner cases
    bus_write(32'h08, 32'h5);
    bus_read("irq_en_write5", 32'h08, 32'h0);
    bus_write(32'h08, 32'h1);
    bus_read("irq_en_write1", 32'h08, 32'h1);
    bus_write(32'h08, 32'h0);
    bus_write(32'h04, 32'h0001_0081);
    bus_read("change_wide_ignored", 32'h04, 32'h0000_0081);
    bus_write(32'h04, 32'h1);
    bus_read("change_bit0_clr", 32'h04, 32'h0000_0080);
    bus_read("unmapped_10", 32'h10, 32'h0);
    bus_read("unmapped_24", 32'h24, 32'h0);
    bus_write(32'h00, 32'h1234);
    bus_read("value_ro", 32'h00, 32'h0000_0081);
    idle(2);
    check("read_hold", read_data_o, 32'h0000_0081);
    bus_write(32'h08, 32'h1);
    idle(1);
    check("no_retroactive_irq", 32'(interrupt_request_o), 32'h0);

    // 5: return coincides with a new change; W1C and set on the same bit
    sw_i = 16'h0083;
    idle(LAT + 1);
    check("irq_bit1", 32'(interrupt_request_o), 32'h1);
    sw_i = 16'h0087;
    idle(LAT - 1);
    interrupt_return_i = 1'b1;
    tick();
    interrupt_return_i = 1'b0;
    check("irq_return_coincide", 32'(interrupt_request_o), 32'h1);
    interrupt_return_i = 1'b1;
    tick();
    interrupt_return_i = 1'b0;
    check("irq_return_alone", 32'(interrupt_request_o), 32'h0);
    bus_read("change_0086", 32'h04, 32'h0000_0086);
    sw_i = 16'h0083;
    idle(LAT - 1);
    bus_write(32'h04, 32'h4);
    bus_read("change_set_wins", 32'h04, 32'h0000_0086);
    bus_write(32'h04, 32'h4);
    bus_read("change_bit2_clr", 32'h04, 32'h0000_0082);

    // 6: soft reset
    sw_i = 16'h0087;
    idle(LAT + 1);
    check("irq_before_soft_rst", 32'(interrupt_request_o), 32'h1);
    bus_write(32'h24, 32'h1);
    check("soft_rst_irq", 32'(interrupt_request_o), 32'h0);
    bus_read("soft_rst_value", 32'h00, 32'h0);
    bus_read("soft_rst_change", 32'h04, 32'h0);
    bus_read("soft_rst_irq_en", 32'h08, 32'h0);
    idle(LAT + 3);
    bus_write(32'h08, 32'h1);
    bus_write(32'h24, 32'h2);
    bus_read("rst2_irq_en", 32'h08, 32'h1);
    bus_read("rst2_value", 32'h00, 32'h0000_0087);
    bus_read("rst2_change", 32'h04, 32'h0000_0087);
    check("rst2_irq", 32'(interrupt_request_o), 32'h0);

    idle(3);
    check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
